// File: rtl/bcd2bin_pkg.sv
// Shared constants and FSM state type for the BCD-to-binary converter.
// Optional overflow detection is enabled by defining BCD2BIN_OVF_CHECK_EN.
package bcd2bin_pkg;
    localparam int BCD_W     = 4;
    localparam int DEC_BASE  = 10;
    localparam int NDIG_DEF  = 10;
    localparam int VAL_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    function automatic logic is_dec_digit(input logic [BCD_W-1:0] d);
        return d < BCD_W'(DEC_BASE);
    endfunction
endpackage

// File: rtl/mul10_add.sv
// One Horner step: sum = acc*10 + d, built from two shifts and adds so no
// multiplier is needed. The result is widened by BCD_W bits to expose overflow.
module mul10_add
    import bcd2bin_pkg::*;
#(
    parameter int VAL_W = VAL_W_DEF
) (
    input  logic [VAL_W-1:0]       acc,
    input  logic [BCD_W-1:0]       d,
    output logic [VAL_W+BCD_W-1:0] sum
);
    localparam int SUM_W = VAL_W + BCD_W;

    logic [SUM_W-1:0] acc_x;

    assign acc_x = SUM_W'(acc);
    assign sum   = (acc_x << 3) + (acc_x << 1) + SUM_W'(d);
endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter, one digit per cycle, MSD first.
// Defining BCD2BIN_OVF_CHECK_EN enables the sticky ovf flag; otherwise ovf is 0.
module bcd_to_bin
    import bcd2bin_pkg::*;
#(
    parameter int NDIG  = NDIG_DEF,
    parameter int VAL_W = VAL_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BCD_W*NDIG-1:0] digits_flat,
    input  logic [3:0]            num_digits,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [VAL_W-1:0]      value,
    output logic                  err_digit,
    output logic                  err_len,
    output logic                  ovf
);
    localparam logic [3:0] NDIG_MAX = 4'(NDIG);

    state_t                  state;
    logic [BCD_W*NDIG-1:0]   digits;
    logic [3:0]              idx;
    logic [VAL_W-1:0]        acc;
    logic [BCD_W-1:0]        digit_arr [NDIG];
    logic [BCD_W-1:0]        cur_digit;
    logic [VAL_W+BCD_W-1:0]  sum;
    logic                    accept;

    for (genvar g = 0; g < NDIG; g++) begin : g_unpack
        assign digit_arr[g] = digits[g*BCD_W +: BCD_W];
    end

    assign cur_digit = digit_arr[idx];
    assign accept    = (state == IDLE) && in_valid;
    assign value     = acc;

    mul10_add #(.VAL_W(VAL_W)) u_mul10_add (
        .acc (acc),
        .d   (cur_digit),
        .sum (sum)
    );

    // NOTE: every register here updates with <= so all of them see the
    // pre-edge state; the digit latch is reset too, so no X ever reaches sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            digits    <= '0;
            idx       <= '0;
            acc       <= '0;
            err_digit <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        digits    <= digits_flat;
                        acc       <= '0;
                        err_digit <= 1'b0;
                        err_len   <= 1'b0;
                        in_ready  <= 1'b0;
                        if (num_digits == 4'd0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else if (num_digits > NDIG_MAX) begin
                            err_len   <= 1'b1;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            idx   <= num_digits - 4'd1;
                            state <= CONV;
                        end
                    end
                end
                CONV: begin
                    if (!is_dec_digit(cur_digit)) begin
                        err_digit <= 1'b1;
                        acc       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        acc <= sum[VAL_W-1:0];
                        if (idx == 4'd0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            idx <= idx - 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef BCD2BIN_OVF_CHECK_EN
    // Sticky across the whole request; only the carry-out nibble matters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= 1'b0;
        end else if (state == CONV && is_dec_digit(cur_digit)
                     && (sum[VAL_W+BCD_W-1:VAL_W] != '0)) begin
            ovf <= 1'b1;
        end
    end
`else
    logic unused_sum_hi;

    assign unused_sum_hi = |sum[VAL_W+BCD_W-1:VAL_W];
    assign ovf           = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin: conversion, latency, error
// paths, backpressure and asynchronous reset.
module tb_bcd_to_bin;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] digits_flat;
    logic [3:0]  num_digits;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] value;
    logic        err_digit;
    logic        err_len;
    logic        ovf;

    int passed = 0;
    int total  = 0;

`ifdef BCD2BIN_OVF_CHECK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    bcd_to_bin dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .digits_flat (digits_flat),
        .num_digits  (num_digits),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .value       (value),
        .err_digit   (err_digit),
        .err_len     (err_len),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request; lat is the edge (accept edge = 1) after which
    // out_valid was first seen, or -1 if it never came.
    task automatic run_req(input logic [39:0] d, input logic [3:0] n, output int lat);
        @(negedge clk);
        digits_flat = d;
        num_digits  = n;
        in_valid    = 1'b1;
        lat         = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (out_valid) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({in_ready, out_valid, err_digit, err_len, ovf} !== 5'b10000 || value !== 32'd0) begin
            $display("FAIL reset_state: got rdy=%b vld=%b ed=%b el=%b ovf=%b val=%h expected 1 0 0 0 0 0",
                     in_ready, out_valid, err_digit, err_len, ovf, value);
        end else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        run_req(40'h0000000610, 4'd3, lat);
        total++;
        if (lat !== 4) $display("FAIL basic_latency: got %0d expected 4", lat);
        else passed++;
        total++;
        if (value !== 32'd610) $display("FAIL basic_value: got %0d expected 610", value);
        else passed++;
        total++;
        if ({err_digit, err_len, ovf} !== 3'b000)
            $display("FAIL basic_flags: got %b expected 000", {err_digit, err_len, ovf});
        else passed++;
        release_out();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL basic_handoff: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_max();
        int lat;
        run_req(40'h4294967295, 4'd10, lat);
        total++;
        if (lat !== 11) $display("FAIL max_latency: got %0d expected 11", lat);
        else passed++;
        total++;
        if (value !== 32'hFFFF_FFFF || ovf !== 1'b0)
            $display("FAIL max_value: got %h ovf=%b expected ffffffff ovf=0", value, ovf);
        else passed++;
        release_out();
    endtask

    task automatic test_overflow();
        int lat;
        run_req(40'h4294967296, 4'd10, lat);
        total++;
        if (value !== 32'd0) $display("FAIL ovf_value: got %h expected 00000000", value);
        else passed++;
        total++;
        if (ovf !== OVF_EXP) $display("FAIL ovf_flag: got %b expected %b", ovf, OVF_EXP);
        else passed++;
        release_out();
    endtask

    task automatic test_bad_digit();
        int lat;
        run_req(40'h00000001A3, 4'd3, lat);
        total++;
        if (lat !== 3) $display("FAIL bad_digit_latency: got %0d expected 3", lat);
        else passed++;
        total++;
        if (err_digit !== 1'b1 || value !== 32'd0 || err_len !== 1'b0 || ovf !== 1'b0)
            $display("FAIL bad_digit_out: got ed=%b val=%h el=%b ovf=%b expected 1 0 0 0",
                     err_digit, value, err_len, ovf);
        else passed++;
        release_out();
    endtask

    task automatic test_zero_len();
        int lat;
        run_req(40'h0000000123, 4'd0, lat);
        total++;
        if (lat !== 1 || value !== 32'd0 || err_digit !== 1'b0 || err_len !== 1'b0)
            $display("FAIL zero_len: got lat=%0d val=%h ed=%b el=%b expected 1 0 0 0",
                     lat, value, err_digit, err_len);
        else passed++;
        release_out();
    endtask

    task automatic test_err_len();
        int lat;
        run_req(40'h0000000123, 4'd11, lat);
        total++;
        if (lat !== 1 || value !== 32'd0 || err_len !== 1'b1)
            $display("FAIL err_len: got lat=%0d val=%h el=%b expected 1 0 1", lat, value, err_len);
        else passed++;
        release_out();
        total++;
        if (in_ready !== 1'b1) $display("FAIL err_len_handoff: got rdy=%b expected 1", in_ready);
        else passed++;
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        @(negedge clk);
        digits_flat = 40'h0000000610;
        num_digits  = 4'd3;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        // A competing request stays asserted through CONV and DONE.
        digits_flat = 40'h0000000999;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++;
        if (lat !== 4) $display("FAIL bp_latency: got %0d expected 4", lat);
        else passed++;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || value !== 32'd610
                || {err_digit, err_len, ovf} !== 3'b000) bad++;
        end
        total++;
        if (bad !== 0)
            $display("FAIL bp_hold: got %0d unstable cycles (val=%0d) expected 0", bad, value);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        release_out();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_async_reset();
        int lat;
        @(negedge clk);
        digits_flat = 40'h4294967295;
        num_digits  = 4'd10;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (value !== 32'd4 || in_ready !== 1'b0)
            $display("FAIL arst_pre: got val=%0d rdy=%b expected 4 0", value, in_ready);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, err_digit, err_len, ovf} !== 5'b10000 || value !== 32'd0)
            $display("FAIL arst_now: got rdy=%b vld=%b ed=%b el=%b ovf=%b val=%h expected 1 0 0 0 0 0",
                     in_ready, out_valid, err_digit, err_len, ovf, value);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        run_req(40'h0000000610, 4'd3, lat);
        total++;
        if (lat !== 4 || value !== 32'd610)
            $display("FAIL arst_after: got lat=%0d val=%0d expected 4 610", lat, value);
        else passed++;
        release_out();
    endtask

    initial begin
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        digits_flat = '0;
        num_digits  = '0;
        test_reset();
        test_basic();
        test_max();
        test_overflow();
        test_bad_digit();
        test_zero_len();
        test_err_len();
        test_backpressure();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential decimal-to-binary converter, the inverse of the existing binary-to-digits path. It accepts a packed BCD digit vector plus a significant-digit count over a valid/ready handshake. It produces the 32-bit binary value by Horner accumulation (acc = acc*10 + digit), most significant digit first, at one digit per cycle. On the DE2 core it parses decimal operands entered from switches, keypad or UART before they are written to a memory-mapped register.

## Interface
- NDIG, 10: maximum number of BCD digits; digits_flat width is 4*NDIG.
- VAL_W, 32: binary result width.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  request present.
- in_ready  out  1  converter idle and able to accept a request.
- digits_flat  in  4*NDIG  digit i at bits [4i+3:4i]; digit 0 is least significant.
- num_digits  in  4  number of significant digits, 0..NDIG.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- value  out  VAL_W  converted result.
- err_digit  out  1  a processed digit was greater than 9.
- err_len  out  1  num_digits was greater than NDIG.
- ovf  out  1  true value exceeded 2^VAL_W-1 (see Configuration).

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch digits_flat;
  - idx = num_digits-1;
  - acc = 0;
  - clear all flags;
  - go to CONV.
- Special cases in IDLE:
  - num_digits=0: go directly to DONE with value 0.
  - num_digits>NDIG: go directly to DONE with err_len=1 and value 0.
- CONV, each cycle:
  - d = latched digit[idx].
  - If d>9: set err_digit, force value 0, go to DONE (abort).
  - Otherwise: acc <= (acc*10 + d) computed at VAL_W+4 bits, then truncated to VAL_W.
  - If the untruncated sum is at least 2^VAL_W, ovf becomes sticky 1.
  - When idx=0, go to DONE; otherwise decrement idx.
- DONE: out_valid=1. value and flags are held stable until out_valid&&out_ready, then return to IDLE.
- in_ready is 0 in CONV and DONE. Inputs change while busy are ignored.
- With NDIG=10 only the top digit step can overflow. The 36-bit intermediate is sufficient for that.

## Timing
- Reset values: in_ready=1, out_valid=0, value=0, err_digit=0, err_len=0, ovf=0, FSM=IDLE, acc=0, idx=0.
- Latency: accept edge at cycle 0 → out_valid high after edge num_digits+1.
  - num_digits=0 or num_digits>NDIG: out_valid high after edge 1.
  - Invalid digit at step k (k-th processed digit, 1-based): out_valid high after edge k+1.
- out_valid deasserts at the edge where out_ready is sampled high. in_ready rises at the same edge.
- No back-to-back accept in the same cycle as result handoff. Throughput is one request per num_digits+2 cycles minimum.
- Reset asserted mid-CONV or in DONE: all outputs return to reset values immediately (asynchronous). The pending result is discarded.
- Outputs are registered; no combinational path from inputs to outputs except none (in_ready depends only on state).

## Configuration
- BCD2BIN_OVF_CHECK_EN defined:
  - ovf is computed as described.
  - value is the low VAL_W bits of the true result.
- BCD2BIN_OVF_CHECK_EN undefined:
  - ovf is tied to 0.
  - Overflow-compare logic is removed.
  - value still wraps modulo 2^VAL_W.

## Structure
- Package bcd2bin_pkg holds:
  - FSM state typedef (IDLE/CONV/DONE);
  - BCD_W=4;
  - DEC_BASE=10;
  - default NDIG and VAL_W constants.
- Sub-module mul10_add: combinational, inputs acc[VAL_W-1:0] and d[3:0], output sum[VAL_W+3:0] = (acc<<3)+(acc<<1)+d. Synthesis must map it to shift-add, with no multiplier.
- Top-level bcd_to_bin holds the FSM, digit latch, idx counter, accumulator and flags.

## Test plan
- digits 0,6,1,0 (digits_flat=40'h0000000610), num_digits=3 → value=610 (0x262), out_valid after edge 4, no flags.
- 4294967295, num_digits=10 → value=0xFFFFFFFF, ovf=0. 4294967296 → value=0, ovf=1 with macro defined, ovf=0 without.
- digits_flat=40'h00000001A3, num_digits=3 (middle digit 0xA) → err_digit=1, value=0, out_valid after edge 3.
- num_digits=0 → value=0 after edge 1. num_digits=11 → err_len=1, value=0 after edge 1.
- 610 conversion with out_ready held low 5 cycles:
  - value and flags stay stable while out_valid=1;
  - in_valid pulses during CONV/DONE are ignored;
  - release out_ready → in_ready=1 next cycle.
- Assert rst_n low in CONV step 2 of a 10-digit request → outputs return to reset values without waiting for clk. A fresh 610 request then converts correctly.
